// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types, frame constants and parity helper used by
//               the host transmitter and the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  // Transmitter state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INHIBIT = 2'd1,
    START   = 2'd2,
    DATA    = 2'd3
  } tx_state_e;

  // Frame: start, 8 data, parity, stop
  localparam int c_FRAME_LEN = 11;
  // The 11th device clock fall is the acknowledge slot
  localparam int c_ACK_IDX   = 11;

  // 100 us inhibit and 15 ms watchdog at a 50 MHz system clock
  localparam int c_INHIBIT_CYCLES_DEF = 5000;
  localparam int c_TIMEOUT_CYCLES_DEF = 750000;

  // Odd parity: the returned bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_tx_ps2_if.sv
// ============================================================================
// Module      : fsm_tx_ps2_if
// Description : Host-side request/status and bus-side line signals of the
//               PS/2 host transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_tx_ps2_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2_d;
  logic       fall_edge;
  logic       ps2_c_oe;
  logic       ps2_d_oe;
  logic       tx_idle;
  logic       tx_done;
  logic       ack_err;

  // Controller side: issues requests, supplies line levels, watches status
  modport master (
    output wr_ps2, din, ps2_d, fall_edge,
    input  ps2_c_oe, ps2_d_oe, tx_idle, tx_done, ack_err
  );

  // Transmitter side
  modport slave (
    input  wr_ps2, din, ps2_d, fall_edge,
    output ps2_c_oe, ps2_d_oe, tx_idle, tx_done, ack_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_tx_timer.sv
// ============================================================================
// Module      : ps2_tx_timer
// Description : Loadable up-counter with synchronous clear and a terminal
//               count flag; serves as both inhibit timer and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_tx_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over load, load wins over increment
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag is high while the count sits on the selected terminal value
  assign tc_o = (count_q == term_i);

endmodule

`default_nettype wire

// File: rtl/fsm_tx_ps2.sv
// ============================================================================
// Module      : fsm_tx_ps2
// Description : PS/2 host-to-device transmitter. Runs request-to-send,
//               shifts a byte out LSB-first with odd parity and stop on
//               device clock falls, and checks the device acknowledge.
//               Drives the bus only through open-drain pull-down enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_tx_ps2
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = c_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  fsm_tx_ps2_if.slave bus
);

  localparam int c_cnt_max = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                               : TIMEOUT_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_bit_w   = $clog2(c_ACK_IDX + 1);

  // Terminal values are one less than the lengths: the count starts at 0
  localparam logic [c_cnt_w-1:0] c_inh_term = c_cnt_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_to_term  = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_ACK_IDX - 1);

  tx_state_e              state_q;
  logic [c_FRAME_LEN-1:0] frame_q;
  logic [c_bit_w-1:0]     bit_cnt_q;
  logic                   c_oe_q;
  logic                   d_oe_q;
  logic                   idle_q;
  logic                   done_q;
  logic                   err_q;

  logic                   w_tmr_clr;
  logic                   w_tmr_en;
  logic [c_cnt_w-1:0]     w_tmr_term;
  logic                   w_tmr_tc;

  // Shared timer control: cleared outside the timed states and on every
  // device clock fall, counting through INHIBIT and DATA
  always_comb begin
    w_tmr_clr  = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_term = c_to_term;
    case (state_q)
      IDLE:    w_tmr_clr = 1'b1;
      INHIBIT: begin
        w_tmr_en   = 1'b1;
        w_tmr_term = c_inh_term;
      end
      START:   w_tmr_clr = 1'b1;
      DATA: begin
        w_tmr_clr = bus.fall_edge;
        w_tmr_en  = 1'b1;
      end
      default: w_tmr_clr = 1'b1;
    endcase
  end

  ps2_tx_timer #(
    .W (c_cnt_w)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (w_tmr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (w_tmr_en),
    .term_i     (w_tmr_term),
    .tc_o       (w_tmr_tc)
  );

  // Transmit FSM with registered bus enables and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          c_oe_q <= 1'b0;
          d_oe_q <= 1'b0;
          idle_q <= 1'b1;
          if (bus.wr_ps2) begin
            frame_q   <= {1'b1, odd_parity(bus.din), bus.din, 1'b0};
            bit_cnt_q <= '0;
            c_oe_q    <= 1'b1;
            idle_q    <= 1'b0;
            state_q   <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Device clock activity is meaningless while we hold it low
          if (w_tmr_tc) begin
            d_oe_q  <= ~frame_q[0];
            state_q <= START;
          end
        end
        START: begin
          c_oe_q  <= 1'b0;
          state_q <= DATA;
        end
        DATA: begin
          if (bus.fall_edge) begin
            if (bit_cnt_q == c_last_bit) begin
              // Acknowledge slot: the device pulls data low to accept
              done_q  <= ~bus.ps2_d;
              err_q   <= bus.ps2_d;
              d_oe_q  <= 1'b0;
              idle_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Ones shift in so the line stays released after the stop bit
              frame_q   <= {1'b1, frame_q[c_FRAME_LEN-1:1]};
              d_oe_q    <= ~frame_q[1];
              bit_cnt_q <= bit_cnt_q + c_bit_w'(1);
            end
          end else if (w_tmr_tc) begin
            err_q   <= 1'b1;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            idle_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          c_oe_q  <= 1'b0;
          d_oe_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ps2_c_oe = c_oe_q;
  assign bus.ps2_d_oe = d_oe_q;
  assign bus.tx_idle  = idle_q;
  assign bus.tx_done  = done_q;
  assign bus.ack_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_tx_ps2.sv
// ============================================================================
// Module      : tb_fsm_tx_ps2
// Description : Self-checking bench for fsm_tx_ps2 with a PS/2 device model
//               clocking every 40 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_tx_ps2;

  localparam int c_INH    = 20;
  localparam int c_TO     = 200;
  localparam int c_PERIOD = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_pull = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fsm_tx_ps2_if ifc ();

  // Open-drain data line: low if either side pulls
  assign ifc.ps2_d = ~(ifc.ps2_d_oe | dev_pull);

  fsm_tx_ps2 #(
    .INHIBIT_CYCLES (c_INH),
    .TIMEOUT_CYCLES (c_TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_c_oe"}, 32'(ifc.ps2_c_oe), 32'd0);
    check({tag, "_d_oe"}, 32'(ifc.ps2_d_oe), 32'd0);
    check({tag, "_idle"}, 32'(ifc.tx_idle), 32'd1);
    check({tag, "_done"}, 32'(ifc.tx_done), 32'd0);
    check({tag, "_err"},  32'(ifc.ack_err), 32'd0);
  endtask

  // One host-to-device transfer. last_fall < 11: device stops clocking.
  // rst_fall > 0: reset coincides with that fall. wr_mid: extra request
  // issued during the data phase.
  task automatic run_frame(input logic [7:0] d, input bit ack_hi,
                           input int last_fall, input int rst_fall,
                           input bit wr_mid);
    logic [10:0] seen;
    logic [10:0] expect_bits;
    int          n;
    int          ones;
    seen = '0;
    ones = $countones(d);
    // start 0, data LSB first, parity making total ones odd, stop 1
    expect_bits = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};

    ifc.din    = d;
    ifc.wr_ps2 = 1'b1;
    tick();
    ifc.wr_ps2 = 1'b0;
    ifc.din    = ~d;
    check("accept_c_oe", 32'(ifc.ps2_c_oe), 32'd1);
    check("accept_idle", 32'(ifc.tx_idle), 32'd0);

    n = 0;
    while (ifc.ps2_c_oe === 1'b1 && ifc.ps2_d_oe === 1'b0 && n < 1000) begin
      n++;
      tick();
    end
    check("inhibit_len", 32'(n), 32'(c_INH));
    check("start_c_oe", 32'(ifc.ps2_c_oe), 32'd1);
    check("start_d_oe", 32'(ifc.ps2_d_oe), 32'd1);
    tick();
    check("data_c_oe", 32'(ifc.ps2_c_oe), 32'd0);

    for (int k = 1; k <= last_fall; k++) begin
      if (wr_mid && k == 3) begin
        ifc.din    = 8'h5A;
        ifc.wr_ps2 = 1'b1;
        tick();
        ifc.wr_ps2 = 1'b0;
        check("wr_mid_idle", 32'(ifc.tx_idle), 32'd0);
        check("wr_mid_c_oe", 32'(ifc.ps2_c_oe), 32'd0);
        repeat (c_PERIOD - 2) tick();
      end else begin
        repeat (c_PERIOD - 1) tick();
      end
      seen[k-1] = ifc.ps2_d;
      if (k == 11) dev_pull = ~ack_hi;
      if (k == rst_fall) rst = 1'b1;
      ifc.fall_edge = 1'b1;
      tick();
      ifc.fall_edge = 1'b0;
      if (k == rst_fall) begin
        rst = 1'b0;
        check_idle_outs("rst_mid");
        tick();
        check_idle_outs("rst_mid_after");
        return;
      end
      if (k == 11) begin
        dev_pull = 1'b0;
        check("ack_done", 32'(ifc.tx_done), ack_hi ? 32'd0 : 32'd1);
        check("ack_err",  32'(ifc.ack_err), ack_hi ? 32'd1 : 32'd0);
        check("ack_idle", 32'(ifc.tx_idle), 32'd1);
        check("ack_d_oe", 32'(ifc.ps2_d_oe), 32'd0);
        tick();
        check("pulse_done_1cyc", 32'(ifc.tx_done), 32'd0);
        check("pulse_err_1cyc",  32'(ifc.ack_err), 32'd0);
        check("frame_bits", 32'(seen), 32'(expect_bits));
      end
    end

    if (last_fall < 11) begin
      n = 0;
      while (ifc.ack_err !== 1'b1 && n < 1000) begin
        n++;
        tick();
      end
      check("timeout_len", 32'(n), 32'(c_TO));
      check("timeout_c_oe", 32'(ifc.ps2_c_oe), 32'd0);
      check("timeout_d_oe", 32'(ifc.ps2_d_oe), 32'd0);
      check("timeout_idle", 32'(ifc.tx_idle), 32'd1);
      check("timeout_done", 32'(ifc.tx_done), 32'd0);
      tick();
      check("timeout_err_1cyc", 32'(ifc.ack_err), 32'd0);
    end

    repeat (3) tick();
    check("post_idle", 32'(ifc.tx_idle), 32'd1);
    check("post_c_oe", 32'(ifc.ps2_c_oe), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    ifc.wr_ps2    = 1'b1;
    ifc.din       = 8'hAA;
    ifc.fall_edge = 1'b0;

    // Reset held 3 cycles with a request pending: request must be ignored
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outs("in_reset");
    rst        = 1'b0;
    ifc.wr_ps2 = 1'b0;
    tick();
    check_idle_outs("after_reset");
    repeat (5) tick();
    check("reset_wr_ignored", 32'(ifc.tx_idle), 32'd1);

    // Directed frames
    run_frame(8'hF4, 1'b0, 11, 0, 1'b0);
    run_frame(8'h00, 1'b0, 11, 0, 1'b0);
    run_frame(8'hED, 1'b0, 11, 0, 1'b0);
    // Missing acknowledge
    run_frame(8'h3C, 1'b1, 11, 0, 1'b0);
    // Device stops clocking after fall 4
    run_frame(8'hA5, 1'b0, 4, 0, 1'b0);
    // Extra request during data is ignored, frame still completes
    run_frame(8'h81, 1'b0, 11, 0, 1'b1);
    // Reset at fall 6 with an ignored mid-frame request before it
    run_frame(8'h66, 1'b0, 11, 6, 1'b1);
    // Fresh complete frame after reset
    run_frame(8'hF4, 1'b0, 11, 0, 1'b0);

    // Random bytes and acknowledge levels
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      run_frame(rd, 1'($urandom_range(0, 1)), 11, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
